pix_raster_framer: RTL

Parametrised raster framer for the convolution engine's pixel stream. It accepts `LANES` pixels per beat under valid/ready, tracks column and row position against run-time image dimensions, and tags each beat with end-of-row, end-of-frame and per-lane keep flags. A 2-entry skid buffer gives full throughput with registered backpressure. It sits between the pixel producer and the convolution datapath and replaces the single-lane, non-backpressured row/column counter logic.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/pix_skid_buf.sv | 56 +++++
 rtl/pix_raster_framer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and widths for the convolution engine pixel path.
package conv_pkg;

  localparam int unsigned CONV_LANES    = 4;
  localparam int unsigned CONV_PIX_BITS = 8;

  // Tagged beat as seen by the convolution datapath (default lane/pixel widths).
  typedef struct packed {
    logic [CONV_LANES*CONV_PIX_BITS-1:0] data;
    logic [CONV_LANES-1:0]               keep;
    logic                                lastx;
    logic                                lasty;
  } beat_tag_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } frame_state_t;

  // Payload width of a tagged beat for an arbitrary lane/pixel configuration.
  function automatic int unsigned tag_bits(input int unsigned lanes,
                                           input int unsigned pix_bits);
    return lanes * pix_bits + lanes + 2;
  endfunction

endpackage

// File: rtl/pix_skid_buf.sv
// Two-entry valid/ready buffer with a registered not-full flag as input ready.
module pix_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_rdy,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_rdy
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_in_rdy;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;

  assign w_push      = i_valid & r_in_rdy;
  assign w_pop       = (r_count != 2'd0) & i_rdy;
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

  assign o_rdy   = r_in_rdy;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];

  // Storage, pointers, occupancy and the registered ready derived from next occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_in_rdy <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count  <= w_count_nxt;
      r_in_rdy <= (w_count_nxt != 2'd2);
    end
  end

endmodule

// File: rtl/pix_raster_framer.sv
// Raster framer: tags multi-lane pixel beats with row/frame ends and lane keeps.
module pix_raster_framer
  import conv_pkg::*;
#(
  parameter int unsigned XMAX_BITS = 10,
  parameter int unsigned YMAX_BITS = 10,
  parameter int unsigned PIX_BITS  = CONV_PIX_BITS,
  parameter int unsigned LANES     = CONV_LANES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XMAX_BITS-1:0]      img_width,
  input  logic [YMAX_BITS-1:0]      img_height,
  input  logic [LANES*PIX_BITS-1:0] pix_in_data,
  input  logic                      pix_in_valid,
  output logic                      pix_in_rdy,
  output logic [LANES*PIX_BITS-1:0] pix_out_data,
  output logic [LANES-1:0]          pix_out_keep,
  output logic                      pix_out_valid,
  input  logic                      pix_out_rdy,
  output logic                      pix_out_lastx,
  output logic                      pix_out_lasty,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned LOG2L = $clog2(LANES);
  localparam int unsigned DW    = LANES * PIX_BITS;
  localparam int unsigned KW    = XMAX_BITS + LOG2L + 1;
  localparam int unsigned TW    = tag_bits(LANES, PIX_BITS);

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [LANES-1:0] keep;
    logic             lastx;
    logic             lasty;
  } beat_t;

  frame_state_t         r_state;
  logic [XMAX_BITS-1:0] r_w;
  logic [YMAX_BITS-1:0] r_h;
  logic [XMAX_BITS-1:0] r_col;
  logic [YMAX_BITS-1:0] r_row;
  logic [1:0]           r_frames;
  logic                 r_done;

  logic                 w_dims_ok;
  logic [XMAX_BITS-1:0] w_w;
  logic [YMAX_BITS-1:0] w_h;
  logic [XMAX_BITS-1:0] w_bpr_m1;
  logic                 w_lastx;
  logic                 w_lasty;
  logic [KW-1:0]        w_base;
  logic                 w_buf_rdy;
  logic                 w_hs;
  logic                 w_start;
  logic                 w_end_out;
  beat_t                w_in_beat;
  beat_t                w_out_beat;

  // In IDLE the live dimensions tag the first beat; they are latched on that handshake.
  assign w_dims_ok = (r_state == RUN) || ((img_width != '0) && (img_height != '0));
  assign w_w       = (r_state == IDLE) ? img_width  : r_w;
  assign w_h       = (r_state == IDLE) ? img_height : r_h;

  // ceil(W/LANES)-1 == floor((W-1)/LANES) for W >= 1.
  assign w_bpr_m1 = (w_w - XMAX_BITS'(1)) >> LOG2L;
  assign w_lastx  = (r_col == w_bpr_m1);
  assign w_lasty  = (r_row == (w_h - YMAX_BITS'(1)));
  assign w_base   = KW'(r_col) << LOG2L;

  assign pix_in_rdy = w_buf_rdy & w_dims_ok;
  assign w_hs       = pix_in_valid & pix_in_rdy;
  assign w_start    = w_hs & (r_state == IDLE);
  assign w_end_out  = pix_out_valid & pix_out_rdy & pix_out_lastx & pix_out_lasty;

  // Keep generation and zeroing of padding lanes on the last beat of a row.
  always_comb begin
    w_in_beat       = '0;
    w_in_beat.lastx = w_lastx;
    w_in_beat.lasty = w_lasty;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_in_beat.keep[i] = !w_lastx || ((w_base + KW'(i)) < KW'(w_w));
      w_in_beat.data[i*PIX_BITS +: PIX_BITS] =
        w_in_beat.keep[i] ? pix_in_data[i*PIX_BITS +: PIX_BITS] : '0;
    end
  end

  // Input-side frame state, dimension latches and column/row counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_w     <= '0;
      r_h     <= '0;
      r_col   <= '0;
      r_row   <= '0;
    end else if (w_hs) begin
      if (r_state == IDLE) begin
        r_w     <= img_width;
        r_h     <= img_height;
        r_state <= RUN;
      end
      if (w_lastx) begin
        r_col <= '0;
        if (w_lasty) begin
          r_row   <= '0;
          r_state <= IDLE;
        end else begin
          r_row <= r_row + YMAX_BITS'(1);
        end
      end else begin
        r_col <= r_col + XMAX_BITS'(1);
      end
    end
  end

  // Frames in flight (input started, final beat not yet delivered) and the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frames <= 2'd0;
      r_done   <= 1'b0;
    end else begin
      r_frames <= r_frames + {1'b0, w_start} - {1'b0, w_end_out};
      r_done   <= w_end_out;
    end
  end

  assign busy = (r_frames != 2'd0);
  assign done = r_done;

  pix_skid_buf #(
    .WIDTH (TW)
  ) u_skid (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_data  (w_in_beat),
    .i_valid (pix_in_valid & w_dims_ok),
    .o_rdy   (w_buf_rdy),
    .o_data  (w_out_beat),
    .o_valid (pix_out_valid),
    .i_rdy   (pix_out_rdy)
  );

  assign pix_out_data  = w_out_beat.data;
  assign pix_out_keep  = w_out_beat.keep;
  assign pix_out_lastx = w_out_beat.lastx;
  assign pix_out_lasty = w_out_beat.lasty;

endmodule
